// File: rtl/shift_seq_arbiter.sv
// Two-requester round-robin arbiter in front of an iterative barrel shifter.
// The shifter applies one power-of-two stage per cycle, so latency is fixed.
module shift_seq_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [1:0]  op0,
  input  logic [31:0] a0,
  input  logic [4:0]  b0,
  input  logic        req1,
  input  logic [1:0]  op1,
  input  logic [31:0] a1,
  input  logic [4:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic        prio_q, prio_d;
  logic        sel_q, sel_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  amt_q, amt_d;
  logic [31:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q, busy_d;

  // One log-shifter stage: shift by 2^k. SRA keeps a[31] as the fill because
  // the working value's MSB never changes under arithmetic shifts.
  function automatic logic [31:0] applyStage(input logic [1:0] op,
                                             input logic [31:0] w,
                                             input logic [2:0] k);
    logic [4:0]  s;
    logic [63:0] rot;
    s   = 5'd1 << k;
    rot = {w, w} >> s;
    case (op)
      2'b00:   applyStage = w >> s;
      2'b01:   applyStage = w << s;
      2'b10:   applyStage = $signed(w) >>> s;
      default: applyStage = rot[31:0];
    endcase
  endfunction

  logic [7:0] amtExt;
  logic       grantOne;

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    prio_d   = prio_q;
    sel_d    = sel_q;
    op_d     = op_q;
    amt_d    = amt_q;
    work_d   = work_q;
    result_d = result_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    grantOne = 1'b0;
    amtExt   = {3'b000, amt_q};

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grantOne = (req0 && req1) ? prio_q : req1;
          sel_d    = grantOne;
          op_d     = grantOne ? op1 : op0;
          work_d   = grantOne ? a1 : a0;
          amt_d    = grantOne ? b1 : b0;
          stage_d  = 3'd0;
          gnt0_d   = !grantOne;
          gnt1_d   = grantOne;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = amtExt[stage_q] ? applyStage(op_q, work_q, stage_q) : work_q;
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd4) begin
          state_d  = DONE;
          result_d = work_d;
          done0_d  = !sel_q;
          done1_d  = sel_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        prio_d  = !sel_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stage_q  <= 3'd0;
      prio_q   <= RR_INIT;
      sel_q    <= 1'b0;
      op_q     <= 2'b00;
      amt_q    <= 5'd0;
      work_q   <= 32'h0;
      result_q <= 32'h0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      prio_q   <= prio_d;
      sel_q    <= sel_d;
      op_q     <= op_d;
      amt_q    <= amt_d;
      work_q   <= work_d;
      result_q <= result_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign busy   = busy_q;

endmodule
